// File: rtl/ad9280_scop_pkg.sv
// Shared definitions for the AD9280 scope AXI4-Lite register file:
// word map, control bit positions, response codes and FSM/payload types.
package ad9280_scop_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned NUM_RW = 4;

    localparam logic [IDX_W-1:0] REG_CTRL    = 3'd0;
    localparam logic [IDX_W-1:0] REG_DEPTH   = 3'd1;
    localparam logic [IDX_W-1:0] REG_TRIG    = 3'd2;
    localparam logic [IDX_W-1:0] REG_USER    = 3'd3;
    localparam logic [IDX_W-1:0] REG_STATUS  = 3'd4;
    localparam logic [IDX_W-1:0] REG_COUNT   = 3'd5;
    localparam logic [IDX_W-1:0] REG_VERSION = 3'd6;

    localparam int unsigned START    = 0;
    localparam int unsigned CLR_DONE = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } w_state_t;
    typedef enum logic { R_IDLE, R_DATA } r_state_t;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } wr_req_t;

    // Words 0-3 are the only software-writable words.
    function automatic logic is_rw_word(input logic [IDX_W-1:0] idx);
        return idx < IDX_W'(NUM_RW);
    endfunction

endpackage

// File: rtl/ad9280_scop_wstrb_merge.sv
// Byte-lane merge: each byte of new_data replaces old_data where its strobe is set.
module ad9280_scop_wstrb_merge
    import ad9280_scop_pkg::*;
(
    input  logic [DATA_W-1:0] old_data,
    input  logic [DATA_W-1:0] new_data,
    input  logic [STRB_W-1:0] strb,
    output logic [DATA_W-1:0] merged_c
);

    always_comb begin
        merged_c = old_data;
        for (int b = 0; b < int'(STRB_W); b++) begin
            if (strb[b]) merged_c[8*b +: 8] = new_data[8*b +: 8];
        end
    end

endmodule

// File: rtl/ad9280_scop_s_axi_regs.sv
// AXI4-Lite slave register file for the AD9280 scope: capture configuration
// out to the capture core, capture status back to software.
module ad9280_scop_s_axi_regs
    import ad9280_scop_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
    parameter logic [31:0] VERSION            = 32'h0928_0002
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    output logic [31:0]                       cfg_ctrl,
    output logic [31:0]                       cfg_depth,
    output logic [31:0]                       cfg_trig_level,
    output logic [31:0]                       cfg_user,
    output logic                              cap_start,
    input  logic                              cap_busy,
    input  logic                              cap_done,
    input  logic [31:0]                       cap_count
);

    w_state_t w_state_q, w_state_d;
    r_state_t r_state_q, r_state_d;
    logic aw_held_q, aw_held_d, w_held_q, w_held_d;
    wr_req_t req_q, req_d, cur_c;
    logic [NUM_RW-1:0][DATA_W-1:0] regs_q, regs_d;
    logic done_q, done_d, cap_start_q, cap_start_d;
    logic awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
    logic arready_q, arready_d, rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d, rd_mux_c, merged_c;
    logic aw_hs_c, w_hs_c, ar_hs_c, clr_done_c;
    logic [IDX_W-1:0] rd_idx_c;
    logic unused_c;

    assign unused_c = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};
    assign aw_hs_c  = s00_axi_awvalid && awready_q;
    assign w_hs_c   = s00_axi_wvalid && wready_q;
    assign ar_hs_c  = s00_axi_arvalid && arready_q;
    assign rd_idx_c = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];

    // Write payload for this cycle: held copy if already captured, else the live bus.
    always_comb begin
        cur_c.idx  = aw_held_q ? req_q.idx  : s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
        cur_c.data = w_held_q  ? req_q.data : s00_axi_wdata;
        cur_c.strb = w_held_q  ? req_q.strb : s00_axi_wstrb;
    end

    ad9280_scop_wstrb_merge u_merge (
        .old_data (regs_q[cur_c.idx[1:0]]),
        .new_data (cur_c.data),
        .strb     (cur_c.strb),
        .merged_c (merged_c)
    );

    always_comb begin
        w_state_d   = w_state_q;
        aw_held_d   = aw_held_q;
        w_held_d    = w_held_q;
        req_d       = req_q;
        regs_d      = regs_q;
        awready_d   = awready_q;
        wready_d    = wready_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        cap_start_d = 1'b0;
        clr_done_c  = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                if (aw_hs_c) begin
                    aw_held_d = 1'b1;
                    req_d.idx = cur_c.idx;
                end
                if (w_hs_c) begin
                    w_held_d   = 1'b1;
                    req_d.data = cur_c.data;
                    req_d.strb = cur_c.strb;
                end
                if (aw_held_d && w_held_d) begin
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    w_state_d = W_RESP;
                    if (is_rw_word(cur_c.idx)) begin
                        regs_d[cur_c.idx[1:0]] = merged_c;
                        bresp_d = RESP_OKAY;
                        // START and CLR_DONE are strobes, never stored.
                        if (cur_c.idx == REG_CTRL) begin
                            cap_start_d = merged_c[START];
                            clr_done_c  = merged_c[CLR_DONE];
                            regs_d[0][START]    = 1'b0;
                            regs_d[0][CLR_DONE] = 1'b0;
                        end
                    end else begin
                        bresp_d = RESP_SLVERR;
                    end
                end
                awready_d = !aw_held_d && (w_state_d == W_IDLE);
                wready_d  = !w_held_d && (w_state_d == W_IDLE);
            end
            W_RESP: begin
                if (s00_axi_bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        done_d = cap_done || (done_q && !clr_done_c);
    end

    always_comb begin
        unique case (rd_idx_c)
            REG_CTRL:    rd_mux_c = regs_q[0];
            REG_DEPTH:   rd_mux_c = regs_q[1];
            REG_TRIG:    rd_mux_c = regs_q[2];
            REG_USER:    rd_mux_c = regs_q[3];
            REG_STATUS:  rd_mux_c = {{(DATA_W-2){1'b0}}, done_q, cap_busy};
            REG_COUNT:   rd_mux_c = cap_count;
            REG_VERSION: rd_mux_c = VERSION;
            default:     rd_mux_c = '0;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        unique case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs_c) begin
                    rdata_d   = rd_mux_c;
                    rresp_d   = RESP_OKAY;
                    rvalid_d  = 1'b1;
                    arready_d = 1'b0;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (s00_axi_rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            w_state_q   <= W_IDLE;
            r_state_q   <= R_IDLE;
            aw_held_q   <= 1'b0;
            w_held_q    <= 1'b0;
            req_q       <= '0;
            regs_q      <= '0;
            done_q      <= 1'b0;
            cap_start_q <= 1'b0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= RESP_OKAY;
        end else begin
            w_state_q   <= w_state_d;
            r_state_q   <= r_state_d;
            aw_held_q   <= aw_held_d;
            w_held_q    <= w_held_d;
            req_q       <= req_d;
            regs_q      <= regs_d;
            done_q      <= done_d;
            cap_start_q <= cap_start_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            arready_q   <= arready_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
        end
    end

    assign s00_axi_awready = awready_q;
    assign s00_axi_wready  = wready_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = bresp_q;
    assign s00_axi_arready = arready_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = rresp_q;
    assign cfg_ctrl        = regs_q[0];
    assign cfg_depth       = regs_q[1];
    assign cfg_trig_level  = regs_q[2];
    assign cfg_user        = regs_q[3];
    assign cap_start       = cap_start_q;

endmodule

// File: doc/ad9280_scop_s_axi_regs.md
Name: ad9280_scop_s_axi_regs

Overview:
- AXI4-Lite slave register file for the AD9280 scope IP (S00_AXI port); the responder for the VIP master's write/read bursts.
- Holds capture configuration for the sampling datapath and returns capture status to software.
- Sits between the PS AXI interconnect and the ADC capture core, with one clock domain shared with the capture core.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width; 8 words.
- VERSION, 32'h0928_0002, constant returned at word 6.

Ports:
- s00_axi_aclk  in  1  clock.
- s00_axi_areset  in  1  synchronous, active-high reset.
- s00_axi_awaddr  in  5  write address.
- s00_axi_awprot  in  3  ignored.
- s00_axi_awvalid/awready  in/out  1  write address handshake.
- s00_axi_wdata  in  32  write data.
- s00_axi_wstrb  in  4  byte enables.
- s00_axi_wvalid/wready  in/out  1  write data handshake.
- s00_axi_bresp  out  2  write response.
- s00_axi_bvalid/bready  out/in  1  write response handshake.
- s00_axi_araddr  in  5  read address.
- s00_axi_arprot  in  3  ignored.
- s00_axi_arvalid/arready  in/out  1  read address handshake.
- s00_axi_rdata  out  32  read data.
- s00_axi_rresp  out  2  read response.
- s00_axi_rvalid/rready  out/in  1  read data handshake.
- cfg_ctrl  out  32  word 0 value; bit0 is not stored (see Behaviour).
- cfg_depth  out  32  word 1, sample depth.
- cfg_trig_level  out  32  word 2.
- cfg_user  out  32  word 3, scratch/decimation.
- cap_start  out  1  one-cycle pulse.
- cap_busy  in  1  capture status.
- cap_done  in  1  pulse; sets the sticky done flag.
- cap_count  in  32  samples captured.

Behaviour:
- Reset (s00_axi_areset=1 at a clock edge):
  - All ready/valid outputs = 0; bresp = rresp = 0; rdata = 0.
  - Words 0-3 = 0; done_sticky = 0; cap_start = 0.
- Write channel FSM, states W_IDLE, W_RESP:
  - In W_IDLE, AW and W are latched independently. awready=1 until AW is captured; wready=1 until W is captured. Either may arrive first or in the same cycle.
  - On the cycle both are held, the register update occurs and the FSM moves to W_RESP with bvalid=1 on the next cycle.
  - bvalid stays asserted and bresp stays stable until bready. Then return to W_IDLE; awready/wready reassert on the following cycle.
  - Only one outstanding write.
- Write decode on word index awaddr[4:2]; awaddr[1:0] ignored.
  - Words 0-3: each byte is written where its wstrb bit is set; bresp=OKAY.
  - Word 0 bit0 written 1: cap_start pulses for exactly one cycle (the cycle after the write commits). Stored bit0 always reads 0.
  - Word 0 bit1 written 1: clears done_sticky (W1C). Stored bit1 reads 0.
  - Words 4-7: contents unchanged; bresp=SLVERR (2'b10).
- Read channel FSM, states R_IDLE, R_DATA:
  - arready=1 in R_IDLE. On the arvalid&&arready edge, latch the address and move to R_DATA. rvalid=1 on the next cycle with rdata registered.
  - rdata and rresp are held until rready, then return to R_IDLE. Latency from AR handshake to rvalid is 1 cycle.
- Read map:
  - 0-3: stored values.
  - 4: {30'b0, done_sticky, cap_busy}.
  - 5: cap_count.
  - 6: VERSION.
  - 7: 0.
  - All reads return rresp=OKAY.
- done_sticky: set by cap_done. If a W1C and cap_done occur in the same cycle, the set wins.
- Read and write channels run concurrently. When a read and a write to the same word are in the same cycle, the read returns the old value.
- Reset asserted mid-transaction: all FSMs go to IDLE and any pending response is dropped. The master is expected to reset simultaneously.

Decomposition:
- Package ad9280_scop_pkg holds:
  - Word index localparams REG_CTRL=0, REG_DEPTH=1, REG_TRIG=2, REG_USER=3, REG_STATUS=4, REG_COUNT=5, REG_VERSION=6.
  - CTRL bit positions START=0, CLR_DONE=1.
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
- One sub-module: ad9280_scop_wstrb_merge, a byte-lane merge of old data, new data and wstrb. Used for words 0-3.
- The FSMs stay in the top module.

Test Plan:
- Sequential write then readback: write 1,2,3,4 to 0x00,0x04,0x08,0x0C, then read.
  - Reads return 0 (bit0 cleared), 2, 3, 4 with OKAY.
  - cap_start pulses once, after the first write.
- WSTRB: write 32'hAABBCCDD, strb=4'b1111, to 0x08; then write 32'h11223344, strb=4'b0101. Read of 0x08 returns 32'hAA22CC44.
- AW/W ordering: send W 3 cycles before AW, then AW 3 cycles before W, each with bready held low for 5 cycles.
  - Both writes land.
  - bvalid holds until bready.
  - awready/wready deassert while a write is pending.
- RO and status:
  - Write to 0x10 returns SLVERR and the read of 0x10 is unchanged.
  - Pulse cap_done: a read of 0x10 shows bit1=1. Write 2 to 0x00: the read shows bit1=0.
  - 0x18 returns VERSION; 0x1C returns 0.
- Read backpressure: rready held low for 4 cycles after rvalid. rdata is stable; arready=0 until rready.
- Reset mid-write: assert reset with bvalid high. The next cycle shows bvalid=0, and words 0-3 read back 0.
